// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-port controllers: FSM encoding and
// beat-counter width.
package fifo_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam int unsigned BEAT_CNT_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority pick: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_pick #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic [ID_WIDTH-1:0] grant,
   output logic                found
);

   int unsigned idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(rr_ptr) + k) % NUM_REQ;
         if (!found && req[idx[ID_WIDTH-1:0]]) begin
            found = 1'b1;
            grant = idx[ID_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting NUM_REQ write requesters bursts of up to
// BURST_LEN beats into a single shared FIFO write port.
module fifo_wr_arbiter
   import fifo_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            m_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] m_data,
   output logic [NUM_REQ-1:0]            m_ack,
   output logic                          s_write_req,
   output logic [DATA_WIDTH-1:0]         s_write_data,
   input  logic                          s_write_ready,
   output logic                          grant_valid,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   localparam logic [BEAT_CNT_W-1:0] BURST_LAST = BEAT_CNT_W'(BURST_LEN - 1);
   localparam logic [ID_WIDTH-1:0]   LAST_ID    = ID_WIDTH'(NUM_REQ - 1);

   state_t                  state, state_nxt;
   logic [ID_WIDTH-1:0]     rr_ptr;
   logic [ID_WIDTH-1:0]     ptr_after;
   logic [BEAT_CNT_W-1:0]   beat_cnt;
   logic [ID_WIDTH-1:0]     pick_id;
   logic                    pick_found;
   logic                    own_req;
   logic                    ack_beat;
   logic                    burst_done;

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_rr_pick (
      .req    (m_req),
      .rr_ptr (rr_ptr),
      .grant  (pick_id),
      .found  (pick_found)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|m_req) state_nxt = ARB;
         ARB:     state_nxt = pick_found ? XFER : IDLE;
         XFER:    if (burst_done) state_nxt = (|m_req) ? ARB : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_valid = (state == XFER);
      busy        = (state != IDLE);
   end

   // Slices are selected by comparing against each constant index so every
   // part-select has a fixed base.
   always_comb begin
      m_ack        = '0;
      own_req      = 1'b0;
      s_write_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_id == ID_WIDTH'(i)) begin
            own_req  = m_req[i];
            m_ack[i] = grant_valid & m_req[i] & s_write_ready;
            if (grant_valid) s_write_data = m_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign s_write_req = |m_ack;
   assign ack_beat    = s_write_req;
   assign burst_done  = grant_valid & ((ack_beat & (beat_cnt == BURST_LAST)) | ~own_req);
   assign ptr_after   = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
      end else begin
         if (state == ARB && pick_found) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
         end
         if (ack_beat)   beat_cnt <= beat_cnt + 1'b1;
         if (burst_done) rr_ptr   <= ptr_after;
      end
   end

   a_ack_onehot0 : assert property (@(posedge clk) disable iff (!reset) $onehot0(m_ack));
   a_no_write_full : assert property (@(posedge clk) disable iff (!reset) !(s_write_req && !s_write_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requesters hold m_req until their job
// of N beats is acked; a round-robin job model predicts the write sequence.
module tb_fifo_wr_arbiter;

   localparam int unsigned NR  = 4;
   localparam int unsigned DW  = 64;
   localparam int unsigned BL  = 8;
   localparam int unsigned IDW = $clog2(NR);

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [NR-1:0]        m_req = '0;
   logic [NR*DW-1:0]     m_data = '0;
   logic [NR-1:0]        m_ack;
   logic                 s_write_req;
   logic [DW-1:0]        s_write_data;
   logic                 s_write_ready = 1'b1;
   logic                 grant_valid;
   logic [IDW-1:0]       grant_id;
   logic                 busy;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .BURST_LEN  (BL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .m_req         (m_req),
      .m_data        (m_data),
      .m_ack         (m_ack),
      .s_write_req   (s_write_req),
      .s_write_data  (s_write_data),
      .s_write_ready (s_write_ready),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned   id;
      logic [DW-1:0] data;
   } beat_t;

   beat_t         exp_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] payload [NR][32];
   int unsigned   rem [NR];
   int unsigned   bidx [NR];
   int unsigned   m_ptr = 0;
   int            ready_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: invariants every cycle, scoreboard pop on every FIFO write.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         check("ack_onehot0", 64'($onehot0(m_ack)), 64'd1);
         check("wr_eq_ack", 64'(s_write_req), 64'(|m_ack));
         if (!s_write_ready) check("no_wr_when_full", 64'(s_write_req), 64'd0);
         if (s_write_req) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'(s_write_req), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("wr_grant_id", 64'(grant_id), 64'(e.id));
               check("wr_data", s_write_data, e.data);
               check("wr_ack_bit", 64'(m_ack), 64'(1) << e.id);
            end
         end
      end
   end

   // Job-level model: serve the first requester with work at or after the
   // pointer, up to BL beats, then move the pointer past it.
   task automatic model_push();
      int unsigned r [NR];
      int unsigned used [NR];
      int          sel;
      int unsigned n;
      beat_t       e;
      for (int i = 0; i < NR; i++) begin
         r[i] = rem[i];
         used[i] = 0;
      end
      forever begin
         sel = -1;
         for (int k = 0; k < NR; k++) begin
            if (sel < 0 && r[(m_ptr + k) % NR] > 0) sel = int'((m_ptr + k) % NR);
         end
         if (sel < 0) break;
         n = (r[sel] < BL) ? r[sel] : BL;
         for (int b = 0; b < int'(n); b++) begin
            e.id = sel;
            e.data = payload[sel][used[sel] + b];
            exp_q.push_back(e);
         end
         used[sel] += n;
         r[sel] -= n;
         m_ptr = (sel + 1) % NR;
      end
   endtask

   task automatic load(input int unsigned r0, input int unsigned r1,
                       input int unsigned r2, input int unsigned r3);
      rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
      for (int i = 0; i < NR; i++) begin
         bidx[i] = 0;
         for (int b = 0; b < 32; b++) payload[i][b] = {$urandom, $urandom};
      end
      model_push();
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         m_req[i] = (rem[i] > 0);
         m_data[i*DW +: DW] = payload[i][bidx[i]];
      end
   endtask

   task automatic run_phase(input int budget, input bit chk_lat, input bit chk_gap,
                            input int abort_req);
      int            start, last_ack_cyc, id, stall_left, stall_seen;
      int unsigned   last_id;
      bit            seen, done, idle_all;
      logic [NR-1:0] acks;
      seen = 0; done = 0; stall_left = 0; stall_seen = 0;
      last_ack_cyc = 0; last_id = 0; id = 0;
      @(posedge clk); #1;
      start = cyc;
      s_write_ready = 1'b1;
      drive();
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         acks = m_ack;
         if (ready_mode == 2 && !s_write_ready) begin
            stall_seen++;
            check("stall_grant_valid", 64'(grant_valid), 64'd1);
            check("stall_grant_id", 64'(grant_id), 64'd1);
            check("stall_no_ack", 64'(m_ack), 64'd0);
         end
         if (|acks) begin
            for (int i = 0; i < NR; i++) if (acks[i]) id = i;
            if (chk_lat && !seen) check("arb_latency", 64'(cyc - start), 64'd2);
            if (chk_gap && seen && id != int'(last_id))
               check("burst_gap", 64'(cyc - last_ack_cyc), 64'd2);
            seen = 1; last_id = id; last_ack_cyc = cyc;
            rem[id]--; bidx[id]++;
            if (ready_mode == 2 && id == 1 && bidx[1] == 3) stall_left = 5;
            if (abort_req >= 0 && id == abort_req && bidx[id] == 4) begin
               #2 reset = 1'b0;
               #1;
               check("abort_grant_valid", 64'(grant_valid), 64'd0);
               check("abort_m_ack", 64'(m_ack), 64'd0);
               check("abort_write_req", 64'(s_write_req), 64'd0);
               check("abort_write_data", s_write_data, 64'd0);
               check("abort_busy", 64'(busy), 64'd0);
               for (int i = 0; i < NR; i++) rem[i] = 0;
               exp_q.delete();
               m_ptr = 0;
               drive();
               done = 1;
            end
         end
         if (!done) begin
            @(posedge clk); #1;
            case (ready_mode)
               0: s_write_ready = 1'b1;
               1: s_write_ready = ($urandom_range(3) != 0);
               default: begin
                  if (stall_left > 0) begin
                     s_write_ready = 1'b0;
                     stall_left--;
                  end else begin
                     s_write_ready = 1'b1;
                  end
               end
            endcase
            drive();
            idle_all = !busy;
            for (int i = 0; i < NR; i++) if (rem[i] != 0) idle_all = 0;
            if (idle_all) done = 1;
         end
      end
      check("phase_completes", 64'(done), 64'd1);
      if (ready_mode == 2) check("stall_cycles", 64'(stall_seen), 64'd5);
      s_write_ready = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         rem[i] = 0;
         bidx[i] = 0;
         for (int b = 0; b < 32; b++) payload[i][b] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_grant_valid", 64'(grant_valid), 64'd0);
      check("rst_grant_id", 64'(grant_id), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_m_ack", 64'(m_ack), 64'd0);
      check("rst_write_req", 64'(s_write_req), 64'd0);
      check("rst_write_data", s_write_data, 64'd0);
      reset = 1'b1;
      m_ptr = 0;

      // Full contention: grants 0,1,2,3,0 with one gap cycle between bursts.
      ready_mode = 0;
      load(16, 8, 8, 8);
      run_phase(400, 0, 1, -1);

      // Backpressure on requester 1 after its third beat.
      ready_mode = 2;
      load(0, 8, 0, 0);
      run_phase(400, 0, 0, -1);

      // Reset at beat 4 of requester 2, then restart from requester 0.
      ready_mode = 0;
      load(0, 0, 8, 0);
      run_phase(400, 0, 0, 2);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      load(0, 4, 4, 0);
      run_phase(400, 0, 0, -1);

      // Single requester 2, three beats, two-cycle arbitration latency.
      load(0, 0, 3, 0);
      run_phase(400, 1, 0, -1);

      // Pointer now at 3: requester 3 first (early release), then wrap to 0.
      load(2, 0, 0, 2);
      run_phase(400, 0, 0, -1);

      ready_mode = 1;
      for (int p = 0; p < 8; p++) begin
         load($urandom_range(0, 20), $urandom_range(0, 20),
              $urandom_range(0, 20), $urandom_range(0, 20));
         run_phase(2000, 0, 0, -1);
      end

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
